// File: rtl/column_window_gen_pkg.sv
// Shared pixel/column defaults and FSM encoding for the column window producer
// and its medianfilter consumer.
package column_window_gen_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int COLUMN_NUM_DEF = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/column_window_gen_line_buffer.sv
// One-line pixel store: asynchronous read, registered write, same address,
// so a read in the write cycle returns the old word. No reset, no backpressure.
module line_buffer
  import column_window_gen_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 640,
  parameter int AW         = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdat,
  output logic [DATA_WIDTH-1:0] rdat
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdat;
    end
  end

  assign rdat = mem_q[addr];

endmodule

// File: rtl/column_window_gen.sv
// Turns a raster pixel stream into 7-pixel vertical columns for medianfilter.
// Columns, refresh and eof are registered one cycle after the accept; never backpressures after reset.
module column_window_gen
  import column_window_gen_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int COLUMN_NUM = COLUMN_NUM_DEF,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int XW         = 10,
  parameter int YW         = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pix_in,
  input  logic                  pix_valid,
  input  logic                  pix_sof,
  output logic                  pix_ready,
  output logic [DATA_WIDTH-1:0] out0,
  output logic [DATA_WIDTH-1:0] out1,
  output logic [DATA_WIDTH-1:0] out2,
  output logic [DATA_WIDTH-1:0] out3,
  output logic [DATA_WIDTH-1:0] out4,
  output logic [DATA_WIDTH-1:0] out5,
  output logic [DATA_WIDTH-1:0] out6,
  output logic                  col_valid,
  output logic                  refresh,
  output logic                  eof
);

  localparam int NLB = COLUMN_NUM - 1;

  state_t  state_q, state_d, cur_state;
  logic [XW-1:0] x_q, x_d, cur_x;
  logic [YW-1:0] y_q, y_d, cur_y;
  logic [COLUMN_NUM-1:0][DATA_WIDTH-1:0] col_q, col_d, col_in;
  logic col_valid_q, col_valid_d;
  logic refresh_q, refresh_d;
  logic eof_q, eof_d;
  logic pix_ready_q;
  logic accept, sof_acc, keep, last_x;
  logic [DATA_WIDTH-1:0] lb_rd [NLB];

  // lb0 holds row y-1, lb(NLB-1) the oldest row; each write shifts the column down one buffer.
  for (genvar k = 0; k < NLB; k++) begin : g_lb
    logic [DATA_WIDTH-1:0] wdat;
    if (k == 0) begin : g_first
      assign wdat = pix_in;
    end else begin : g_chain
      assign wdat = lb_rd[k-1];
    end
    line_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (IMG_WIDTH),
      .AW         (XW)
    ) u_lb (
      .clk  (clk),
      .we   (keep),
      .addr (cur_x),
      .wdat (wdat),
      .rdat (lb_rd[k])
    );
  end

  always_comb begin
    accept    = pix_valid & pix_ready_q;
    sof_acc   = accept & pix_sof;
    keep      = accept & (pix_sof | (state_q != IDLE));
    // A start-of-frame pixel restarts the raster at (0,0) regardless of where we were.
    cur_state = sof_acc ? FILL : state_q;
    cur_x     = sof_acc ? '0 : x_q;
    cur_y     = sof_acc ? '0 : y_q;
    last_x    = (cur_x == XW'(IMG_WIDTH - 1));

    col_in[COLUMN_NUM-1] = pix_in;
    for (int k = 0; k < NLB; k++) begin
      col_in[k] = lb_rd[NLB-1-k];
    end

    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    col_d       = col_q;
    col_valid_d = 1'b0;
    refresh_d   = sof_acc;
    eof_d       = 1'b0;

    if (keep) begin
      state_d = cur_state;
      x_d     = cur_x + XW'(1);
      y_d     = cur_y;
      if (last_x) begin
        x_d = '0;
        y_d = cur_y + YW'(1);
        if (cur_state == FILL && cur_y == YW'(COLUMN_NUM - 2)) begin
          state_d = RUN;
        end
        if (cur_state == RUN && cur_y == YW'(IMG_HEIGHT - 1)) begin
          state_d = IDLE;
          y_d     = '0;
          eof_d   = 1'b1;
        end
      end
      if (cur_state == RUN) begin
        col_valid_d = 1'b1;
        col_d       = col_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      col_q       <= '0;
      col_valid_q <= 1'b0;
      refresh_q   <= 1'b0;
      eof_q       <= 1'b0;
      pix_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      col_q       <= col_d;
      col_valid_q <= col_valid_d;
      refresh_q   <= refresh_d;
      eof_q       <= eof_d;
      pix_ready_q <= 1'b1;
    end
  end

  assign pix_ready = pix_ready_q;
  assign col_valid = col_valid_q;
  assign refresh   = refresh_q;
  assign eof       = eof_q;
  assign out0      = col_q[0];
  assign out1      = col_q[1];
  assign out2      = col_q[2];
  assign out3      = col_q[3];
  assign out4      = col_q[4];
  assign out5      = col_q[5];
  assign out6      = col_q[6];

endmodule

// File: tb/tb_column_window_gen.sv
// Randomized bench for column_window_gen on a 4x8 image, checked every cycle
// against a frame-array reference model.
module tb_column_window_gen;

  localparam int W = 4;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pix_in = 8'h00;
  logic       pix_valid = 1'b0;
  logic       pix_sof = 1'b0;
  logic       pix_ready, col_valid, refresh, eof;
  logic [7:0] out0, out1, out2, out3, out4, out5, out6;

  column_window_gen #(
    .DATA_WIDTH (8),
    .COLUMN_NUM (7),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .XW         (2),
    .YW         (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_sof   (pix_sof),
    .pix_ready (pix_ready),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out4      (out4),
    .out5      (out5),
    .out6      (out6),
    .col_valid (col_valid),
    .refresh   (refresh),
    .eof       (eof)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the frame seen so far and the raster position of the next pixel.
  logic [7:0]  img [H][W];
  int          mx = 0, my = 0;
  bit          in_frame = 0;
  logic [55:0] exp_cols = '0;
  bit          exp_cv = 0, exp_ref = 0, exp_eof = 0, exp_rdy = 0;

  // Per-scenario observations.
  int          col_cnt, eof_cnt, ref_cnt;
  bit          got_first, aa_seen;
  logic [55:0] first_col, last_col;

  function automatic logic [55:0] dut_cols();
    return {out6, out5, out4, out3, out2, out1, out0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    col_cnt = 0; eof_cnt = 0; ref_cnt = 0;
    got_first = 0; aa_seen = 0;
    first_col = '0; last_col = '0;
  endtask

  task automatic cyc(input bit v, input bit s, input logic [7:0] p);
    bit acc;
    @(negedge clk);
    pix_valid = v; pix_sof = s; pix_in = p;
    acc = v & exp_rdy;
    exp_cv = 0; exp_ref = 0; exp_eof = 0;
    if (acc && (s || in_frame)) begin
      if (s) begin
        in_frame = 1; mx = 0; my = 0; exp_ref = 1;
      end
      img[my][mx] = p;
      if (my >= 6) begin
        exp_cv = 1;
        for (int k = 0; k < 7; k++) exp_cols[8*k +: 8] = img[my-6+k][mx];
      end
      if (mx == W - 1) begin
        mx = 0;
        if (my == H - 1) begin
          my = 0; in_frame = 0; exp_eof = 1;
        end else begin
          my++;
        end
      end else begin
        mx++;
      end
    end
    @(posedge clk);
    #1;
    exp_rdy = rst;
    chk("pix_ready", 64'(pix_ready), 64'(exp_rdy));
    chk("col_valid", 64'(col_valid), 64'(exp_cv));
    chk("refresh", 64'(refresh), 64'(exp_ref));
    chk("eof", 64'(eof), 64'(exp_eof));
    chk("column", 64'(dut_cols()), 64'(exp_cols));
    if (col_valid) begin
      col_cnt++;
      if (!got_first) first_col = dut_cols();
      got_first = 1;
      last_col = dut_cols();
    end
    if (eof) eof_cnt++;
    if (refresh) ref_cnt++;
    if (out0 == 8'hAA || out1 == 8'hAA || out2 == 8'hAA || out3 == 8'hAA ||
        out4 == 8'hAA || out5 == 8'hAA || out6 == 8'hAA) aa_seen = 1;
  endtask

  // Sends raster pixels lo..hi-1 of a 16*y+x frame; index 0 carries sof.
  task automatic send_px(input int gap_pct, input int lo, input int hi);
    for (int idx = lo; idx < hi; idx++) begin
      for (int g = 0; g < 5 && $urandom_range(0, 99) < gap_pct; g++) begin
        cyc(1'b0, 1'b0, 8'($urandom));
      end
      cyc(1'b1, idx == 0, 8'(16 * (idx / W) + idx % W));
    end
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_cols"}, 64'(col_cnt), 64'd8);
    chk({tag, "_eofs"}, 64'(eof_cnt), 64'd1);
    chk({tag, "_refresh"}, 64'(ref_cnt), 64'd1);
    chk({tag, "_first"}, 64'(first_col), 64'h60_50_40_30_20_10_00);
    chk({tag, "_last"}, 64'(last_col), 64'h73_63_53_43_33_23_13);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_ready", 64'(pix_ready), 64'd0);
    chk("rst_col_valid", 64'(col_valid), 64'd0);
    chk("rst_refresh", 64'(refresh), 64'd0);
    chk("rst_eof", 64'(eof), 64'd0);
    chk("rst_column", 64'(dut_cols()), 64'd0);
    exp_rdy = 0; exp_cols = '0; exp_cv = 0; exp_ref = 0; exp_eof = 0;
    in_frame = 0; mx = 0; my = 0;
    cyc(1'b1, 1'b1, 8'h11);
    cyc(1'b1, 1'b0, 8'h22);
    #2 rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    clear_stats();
    async_reset();

    // Pixels outside a frame must be dropped.
    clear_stats();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'hAA);
    send_px(0, 0, W * H);
    cyc(1'b0, 1'b0, 8'h00);
    check_frame("full");
    chk("no_aa", 64'(aa_seen), 64'd0);

    // Same frame with random idle cycles between pixels.
    clear_stats();
    send_px(40, 0, W * H);
    cyc(1'b0, 1'b0, 8'h00);
    check_frame("gaps");

    // Restart at y=7,x=1: aborted frame yields 5 columns and no eof.
    clear_stats();
    send_px(0, 0, 29);
    chk("abort_cols", 64'(col_cnt), 64'd5);
    chk("abort_eofs", 64'(eof_cnt), 64'd0);
    clear_stats();
    send_px(0, 0, W * H);
    cyc(1'b0, 1'b0, 8'h00);
    check_frame("restart");

    // Random traffic with occasional sof, including mid-frame and last-pixel sof.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) < 75, $urandom_range(0, 49) == 0, 8'($urandom));
    end

    // Reset in the middle of a frame, then stray pixels and a clean frame.
    send_px(0, 0, 27);
    async_reset();
    clear_stats();
    cyc(1'b1, 1'b0, 8'hAA);
    send_px(20, 0, W * H);
    cyc(1'b0, 1'b0, 8'h00);
    check_frame("post_rst");
    chk("post_rst_no_aa", 64'(aa_seen), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
